// File: rtl/comparator_pkg.sv
// Shared constants and types for the 13-bit comparator: operand width, slice width,
// the operand typedef and a helper that sizes the slice chain.
package comparator_pkg;

    localparam int CMP_WIDTH = 13;
    localparam int SLICE_W   = 4;

    typedef logic [CMP_WIDTH-1:0] operand_t;

    function automatic int slice_count(input int width);
        return (width + SLICE_W - 1) / SLICE_W;
    endfunction

endpackage

// File: rtl/comparator_13bits_if.sv
// Operand/result bundle for comparator_13bits. The LT/GT signals exist only
// when COMPARATOR_13BITS_MAGNITUDE_EN is defined.
interface comparator_13bits_if;
    import comparator_pkg::*;

    operand_t A;
    operand_t B;
    logic     EQ;
    logic     EQ_R;
    logic     MATCH_P;
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
    logic     LT;
    logic     GT;
`endif

    modport master (
        output A, B,
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        input  LT, GT,
`endif
        input  EQ, EQ_R, MATCH_P
    );

    modport slave (
        input  A, B,
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        output LT, GT,
`endif
        output EQ, EQ_R, MATCH_P
    );

endinterface

// File: rtl/comparator_13bits_slice.sv
// One 4-bit unsigned compare slice; the top chains these MSB-first.
module comparator_slice
    import comparator_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               eq,
    output logic               lt,
    output logic               gt
);

    always_comb begin
        eq = (a == b);
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/comparator_13bits.sv
// Equality comparator with registered flag and rising-match pulse; registered
// unsigned LT/GT are added when COMPARATOR_13BITS_MAGNITUDE_EN is defined.
module comparator_13bits
    import comparator_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    output logic             EQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clk,
    input  logic             rst_n,
    output logic             EQ_R,
    output logic             MATCH_P
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
    ,
    output logic             LT,
    output logic             GT
`endif
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int PAD_W  = NSLICE * SLICE_W;

    logic [PAD_W-1:0]  a_pad;
    logic [PAD_W-1:0]  b_pad;
    logic [NSLICE-1:0] s_eq;
    logic [NSLICE-1:0] s_lt;
    logic [NSLICE-1:0] s_gt;
    logic              eq_all;
    logic              lt_all;
    logic              gt_all;

    // Zero-extend so the top slice compares equal on its unused bits.
    always_comb begin
        a_pad              = '0;
        b_pad              = '0;
        a_pad[WIDTH-1:0]   = A;
        b_pad[WIDTH-1:0]   = B;
    end

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        comparator_slice u_slice (
            .a  (a_pad[i*SLICE_W +: SLICE_W]),
            .b  (b_pad[i*SLICE_W +: SLICE_W]),
            .eq (s_eq[i]),
            .lt (s_lt[i]),
            .gt (s_gt[i])
        );
    end

    // The most significant differing slice decides the magnitude result.
    always_comb begin
        eq_all = 1'b1;
        lt_all = 1'b0;
        gt_all = 1'b0;
        for (int i = NSLICE - 1; i >= 0; i--) begin
            if (eq_all) begin
                lt_all = s_lt[i];
                gt_all = s_gt[i];
                eq_all = s_eq[i];
            end
        end
    end

    assign EQ = eq_all;

    logic eq_r_d, eq_r_q;
    logic match_p_d, match_p_q;

    always_comb begin
        eq_r_d    = eq_all;
        match_p_d = eq_all & ~eq_r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_r_q    <= 1'b0;
            match_p_q <= 1'b0;
        end else begin
            eq_r_q    <= eq_r_d;
            match_p_q <= match_p_d;
        end
    end

    assign EQ_R    = eq_r_q;
    assign MATCH_P = match_p_q;

`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
    logic lt_d, lt_q;
    logic gt_d, gt_q;

    always_comb begin
        lt_d = lt_all;
        gt_d = gt_all;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q <= 1'b0;
            gt_q <= 1'b0;
        end else begin
            lt_q <= lt_d;
            gt_q <= gt_d;
        end
    end

    assign LT = lt_q;
    assign GT = gt_q;
`else
    logic unused_mag;
    assign unused_mag = lt_all ^ gt_all;
`endif

endmodule

// File: tb/tb_comparator_13bits.sv
// Randomized self-checking bench for comparator_13bits with a spec-level model;
// LT/GT checks are compiled in with COMPARATOR_13BITS_MAGNITUDE_EN.
module tb_comparator_13bits;
    import comparator_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    comparator_13bits_if cif ();

    comparator_13bits dut (
        .EQ      (cif.EQ),
        .A       (cif.A),
        .B       (cif.B),
        .clk     (clk),
        .rst_n   (rst_n),
        .EQ_R    (cif.EQ_R),
        .MATCH_P (cif.MATCH_P)
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        ,
        .LT      (cif.LT),
        .GT      (cif.GT)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registered results are just the arithmetic relations of the
    // operands seen at the last edge; a pulse means "equal now, not equal last edge".
    logic m_eq_r, m_match, m_lt, m_gt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_eq_r  <= 1'b0;
            m_match <= 1'b0;
            m_lt    <= 1'b0;
            m_gt    <= 1'b0;
        end else begin
            m_match <= (cif.A == cif.B) && !m_eq_r;
            m_eq_r  <= (cif.A == cif.B);
            m_lt    <= (int'(cif.A) < int'(cif.B));
            m_gt    <= (int'(cif.A) > int'(cif.B));
        end
    end

    // Compare process: every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        chk("model_eq",      cif.EQ,      cif.A == cif.B);
        chk("model_eq_r",    cif.EQ_R,    m_eq_r);
        chk("model_match_p", cif.MATCH_P, m_match);
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        chk("model_lt",      cif.LT,      m_lt);
        chk("model_gt",      cif.GT,      m_gt);
        if (rst_n)
            chk("one_hot", 32'(cif.EQ_R) + 32'(cif.LT) + 32'(cif.GT), 32'd1);
`endif
    end

    task automatic set_ab(input logic [12:0] a, input logic [12:0] b);
        @(negedge clk);
        cif.A = a;
        cif.B = b;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [12:0] ra, rb;

    initial begin
        rst_n = 1'b0;
        cif.A = 13'd5;
        cif.B = 13'd9;
        #1;
        chk("reset_eq",      cif.EQ,      1'b0);
        chk("reset_eq_r",    cif.EQ_R,    1'b0);
        chk("reset_match_p", cif.MATCH_P, 1'b0);
        after_edge();
        chk("reset_hold_eq_r", cif.EQ_R, 1'b0);
        cif.A = 13'd9;
        #1;
        chk("reset_eq_comb", cif.EQ, 1'b1);

        // 0 vs 0 coming out of reset
        @(negedge clk);
        cif.A = 13'd0;
        cif.B = 13'd0;
        rst_n = 1'b1;
        #1;
        chk("zero_eq_now", cif.EQ, 1'b1);
        after_edge();
        chk("zero_eq_r",    cif.EQ_R,    1'b1);
        chk("zero_match_p", cif.MATCH_P, 1'b1);
        after_edge();
        chk("zero_match_drop", cif.MATCH_P, 1'b0);

        // 0 vs 4
        set_ab(13'd0, 13'd4);
        #1;
        chk("lt4_eq_now", cif.EQ, 1'b0);
        after_edge();
        chk("lt4_eq_r",    cif.EQ_R,    1'b0);
        chk("lt4_match_p", cif.MATCH_P, 1'b0);
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        chk("lt4_lt", cif.LT, 1'b1);
`endif

        // Full-scale match after mismatch, then hold
        set_ab(13'h1FFF, 13'h1FFF);
        #1;
        chk("max_eq_now", cif.EQ, 1'b1);
        after_edge();
        chk("max_match_p", cif.MATCH_P, 1'b1);
        for (int k = 0; k < 10; k++) begin
            after_edge();
            chk("max_hold_no_pulse", cif.MATCH_P, 1'b0);
            chk("max_hold_eq_r",     cif.EQ_R,    1'b1);
        end

        // Boundaries 0 vs 8191 and 8191 vs 0
        set_ab(13'd0, 13'h1FFF);
        after_edge();
        chk("bnd_lo_eq_r", cif.EQ_R, 1'b0);
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        chk("bnd_lo_lt", cif.LT, 1'b1);
`endif
        set_ab(13'h1FFF, 13'd0);
        after_edge();
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
        chk("bnd_hi_gt", cif.GT, 1'b1);
`endif
        chk("bnd_hi_match_p", cif.MATCH_P, 1'b0);

        // Walking single-bit difference against B = 0
        for (int i = 0; i < 13; i++) begin
            set_ab(13'(1 << i), 13'd0);
            #1;
            chk("walk_eq_now", cif.EQ, 1'b0);
            after_edge();
            chk("walk_eq_r", cif.EQ_R, 1'b0);
`ifdef COMPARATOR_13BITS_MAGNITUDE_EN
            chk("walk_gt", cif.GT, 1'b1);
`endif
        end

        // Re-match after mismatch, then asynchronous reset mid-pulse
        set_ab(13'h0AA, 13'h0AA);
        after_edge();
        chk("rematch_match_p", cif.MATCH_P, 1'b1);
        chk("rematch_eq_r",    cif.EQ_R,    1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_eq_r",    cif.EQ_R,    1'b0);
        chk("async_match_p", cif.MATCH_P, 1'b0);
        chk("async_eq_track", cif.EQ, 1'b1);
        cif.A = 13'd3;
        cif.B = 13'd4;
        #1;
        chk("async_eq_track_ne", cif.EQ, 1'b0);
        @(negedge clk);
        cif.B = 13'd3;
        rst_n = 1'b1;
        after_edge();
        chk("post_reset_pulse", cif.MATCH_P, 1'b1);

        // Randomized traffic, biased towards equal and near-equal operands
        for (int n = 0; n < 1500; n++) begin
            ra = 13'($urandom_range(0, 8191));
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 13'(1 << $urandom_range(0, 12));
                default: rb = 13'($urandom_range(0, 8191));
            endcase
            set_ab(ra, rb);
        end
        after_edge();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comparator_13bits.md
COMPARATOR_13BITS -- requirements
Module: comparator_13bits

Interface
REQ-001 Parameter: WIDTH, default 13, operand width in bits; only 13 is verified.
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-low reset, with the ports below.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 EQ  output  1  combinational equality flag; 1 when A == B.
REQ-006 A  input  WIDTH  operand A (e.g. current time code).
REQ-007 B  input  WIDTH  operand B (e.g. alarm time code).
REQ-008 EQ_R  output  1  EQ registered on clk.
REQ-009 MATCH_P  output  1  single-cycle pulse on a registered 0->1 transition of equality.
REQ-010 LT  output  1  registered A < B, unsigned; present only with the magnitude macro.
REQ-011 GT  output  1  registered A > B, unsigned; present only with the magnitude macro.
REQ-012 Port order SHALL be EQ, A, B first, followed by clk, rst_n, EQ_R, MATCH_P, LT, GT.

Function
REQ-013 EQ SHALL equal 1 iff all WIDTH bits of A and B match; zero latency, with no dependence on clk or rst_n.
REQ-014 EQ_R SHALL take the value of EQ at each rising clk edge (1-cycle latency).
REQ-015 MATCH_P SHALL be 1 for exactly one cycle after an edge where EQ = 1 and the prior EQ_R = 0; otherwise 0.
REQ-016 While A == B is held constant, MATCH_P SHALL NOT re-fire.
REQ-017 A mismatch followed by a re-match SHALL produce a new pulse.
REQ-018 LT and GT SHALL be registered with 1-cycle latency and compare A and B as unsigned values.
REQ-019 Exactly one of EQ_R, LT, GT SHALL be 1 in every cycle after the first clock edge following reset release.
REQ-020 Boundaries: 0 vs 0 gives EQ = 1; 8191 vs 8191 gives EQ = 1; 0 vs 8191 gives LT = 1; 8191 vs 0 gives GT = 1.
REQ-021 A single-bit difference in any bit position, including the MSB and LSB, SHALL give EQ = 0.
REQ-022 X or Z on the inputs is outside scope; no defined behaviour is required.

Reset
REQ-023 While rst_n = 0, EQ_R, MATCH_P, LT and GT SHALL be 0 immediately, with no clock required.
REQ-024 EQ SHALL remain combinational during reset.
REQ-025 On the first rising edge after rst_n rises with A == B, EQ_R SHALL become 1 and MATCH_P SHALL pulse.
REQ-026 Reset asserted mid-pulse SHALL clear MATCH_P at once.

Configuration
REQ-027 The magnitude feature SHALL be controlled by macro COMPARATOR_13BITS_MAGNITUDE_EN.
REQ-028 With COMPARATOR_13BITS_MAGNITUDE_EN defined, the LT and GT ports and their logic SHALL exist.
REQ-029 Without the macro, the LT and GT ports SHALL be absent, and EQ, EQ_R and MATCH_P SHALL behave identically.

Structure
REQ-030 Shared package comparator_pkg SHALL hold the CMP_WIDTH = 13 localparam and a typedef for the 13-bit operand.
REQ-031 Sub-module comparator_slice SHALL compare a 4-bit slice and return eq, lt and gt.
REQ-032 The top SHALL chain slices MSB-first to form the full comparison, padding the top slice for WIDTH = 13.

Verification
REQ-033 A = 0, B = 0 -> EQ = 1 at once; EQ_R = 1 and MATCH_P = 1 one cycle later; MATCH_P = 0 the cycle after.
REQ-034 A = 0, B = 0x0004 -> EQ = 0 at once; EQ_R = 0 and LT = 1 next cycle; no MATCH_P.
REQ-035 A = B = 0x1FFF after a mismatch -> EQ = 1; MATCH_P pulses once; holding for 10 cycles gives no further pulses.
REQ-036 Walking single-bit difference across bits 0..12 with B = 0 -> EQ = 0 and GT = 1 for every position.
REQ-037 Assert rst_n = 0 between edges while EQ_R = 1 -> EQ_R and MATCH_P = 0 without a clock edge; EQ still tracks the inputs.
REQ-038 Build without COMPARATOR_13BITS_MAGNITUDE_EN -> scenarios REQ-033 and REQ-035 pass unchanged and the LT/GT ports are absent.
